ct_f_spsram_acc_ctrl: RTL and testbench

//  Initiator side of the single-port SRAM macro interface (A/CEN/GWEN/WEN/D/Q, all

---
 rtl/ct_f_spsram_acc_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_ct_f_spsram_acc_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_f_spsram_acc_ctrl.sv
// ---------------------------------------------------------------------------
// ct_f_spsram_acc_ctrl
//
// Initiator side of a single-port SRAM macro (A/CEN/GWEN/WEN/D/Q, strobes
// active-low). Turns a valid/ready request stream into SRAM cycles and returns
// read data on a valid/ready response stream with a one-entry skid buffer. It
// also clears the whole array to INIT_VAL after reset and whenever init_req is
// seen while running.
//
// Ports
//   forever_cpuclk  clock, also the SRAM clock
//   cpurst_b        synchronous active-low reset
//   init_req        pulse: restart the clear sweep (taken only while running)
//   init_done       1 = sweep complete, requests may be accepted
//   req_*           request stream (wr, addr, wdata, per-bit wmask 1=write)
//   rsp_*           read response stream (rdata)
//   sram_a/cen/gwen/wen/d  SRAM control/data, driven in the access cycle
//   sram_q          SRAM read data, valid the cycle after a read access
// ---------------------------------------------------------------------------
module ct_f_spsram_acc_ctrl #(
    parameter int                   ADDR_WIDTH = 9,
    parameter int                   DATA_WIDTH = 54,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL  = {DATA_WIDTH{1'b0}}
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_req,
    output logic                  init_done,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // The sweep counter carries one spare bit so it can never wrap back onto
    // entry 0 while still in INIT.
    localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                  state_q,     state_d;
    logic [ADDR_WIDTH:0]     init_cnt_q,  init_cnt_d;
    logic                    init_done_q, init_done_d;
    logic                    init_pend_q, init_pend_d;
    logic                    rd_pend_q,   rd_pend_d;
    logic                    hold_vld_q,  hold_vld_d;
    logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;

    logic                    in_run_s;
    logic                    init_switch_s;
    logic                    req_rdy_s;
    logic                    req_fire_s;

    assign in_run_s = (state_q == ST_RUN);

    // A sweep restart may only start once no read data is in flight, so a
    // pulse that arrives while a read is outstanding is remembered in
    // init_pend_q until the response path drains.
    assign init_switch_s = cpurst_b & in_run_s & (init_req | init_pend_q)
                         & ~rd_pend_q & ~hold_vld_q;

    // Stall when the skid buffer is full or about to be filled this cycle.
    assign req_rdy_s = cpurst_b & in_run_s & ~hold_vld_q
                     & ~(rd_pend_q & ~rsp_rdy) & ~init_switch_s;

    assign req_fire_s = req_vld & req_rdy_s;

    assign req_rdy   = req_rdy_s;
    assign init_done = init_done_q;
    assign rsp_vld   = cpurst_b & (rd_pend_q | hold_vld_q);
    assign rsp_rdata = hold_vld_q ? hold_data_q : sram_q;

    // SRAM pin drive: sweep write, accepted request, or idle.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = {DATA_WIDTH{1'b1}};
        sram_a    = req_addr;
        sram_d    = req_wdata;
        if (!cpurst_b) begin
            sram_cen  = 1'b1;
            sram_gwen = 1'b1;
        end else if (state_q == ST_INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = {DATA_WIDTH{1'b0}};
            sram_a    = init_cnt_q[ADDR_WIDTH-1:0];
            sram_d    = INIT_VAL;
        end else if (req_fire_s) begin
            sram_cen = 1'b0;
            if (req_wr) begin
                sram_gwen = 1'b0;
                sram_wen  = ~req_wmask;
            end else begin
                sram_gwen = 1'b1;
                sram_wen  = {DATA_WIDTH{1'b1}};
            end
        end else begin
            sram_cen  = 1'b1;
            sram_gwen = 1'b1;
        end
    end

    // Next-state logic for the sweep/run FSM and the response path.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        init_pend_d = init_pend_q;
        rd_pend_d   = req_fire_s & ~req_wr;
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;

        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + CNT_ONE;
                if (init_cnt_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    state_d     = ST_INIT;
                end
            end
            ST_RUN: begin
                if (init_switch_s) begin
                    state_d     = ST_INIT;
                    init_cnt_d  = {(ADDR_WIDTH+1){1'b0}};
                    init_done_d = 1'b0;
                    init_pend_d = 1'b0;
                end else if (init_req) begin
                    init_pend_d = 1'b1;
                end else begin
                    init_pend_d = init_pend_q;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = {(ADDR_WIDTH+1){1'b0}};
            end
        endcase

        // The SRAM only presents Q for one cycle, so a stalled response is
        // captured; req_rdy guarantees the buffer is empty when that happens.
        if (rd_pend_q && !rsp_rdy) begin
            hold_vld_d  = 1'b1;
            hold_data_d = sram_q;
        end else if (hold_vld_q && rsp_rdy) begin
            hold_vld_d  = 1'b0;
        end else begin
            hold_vld_d  = hold_vld_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= {(ADDR_WIDTH+1){1'b0}};
            init_done_q <= 1'b0;
            init_pend_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            init_pend_q <= init_pend_d;
            rd_pend_q   <= rd_pend_d;
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
        end
    end

endmodule

// File: tb/tb_ct_f_spsram_acc_ctrl.sv
module tb_ct_f_spsram_acc_ctrl;

    logic        clk = 1'b0;
    logic        cpurst_b = 1'b0;
    logic        rst_b_v = 1'b0;
    logic        init_req = 1'b0;
    logic        init_done;
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic        req_wr = 1'b0;
    logic [8:0]  req_addr = 9'd0;
    logic [53:0] req_wdata = 54'd0;
    logic [53:0] req_wmask = 54'd0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b1;
    logic [53:0] rsp_rdata;
    logic [8:0]  sram_a;
    logic        sram_cen;
    logic        sram_gwen;
    logic [53:0] sram_wen;
    logic [53:0] sram_d;
    logic [53:0] sram_q;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [53:0] ONES  = {54{1'b1}};
    localparam logic [53:0] VAL5  = 54'h3_FFFF_FFFF_FFFF;
    localparam logic [53:0] V3    = 54'h12_3456_789A_BCDE;

    ct_f_spsram_acc_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst_b       (cpurst_b),
        .init_req       (init_req),
        .init_done      (init_done),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .rsp_vld        (rsp_vld),
        .rsp_rdy        (rsp_rdy),
        .rsp_rdata      (rsp_rdata),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: Q is only meaningful the cycle after a read; any other
    // cycle it shows junk so a missing capture of read data is visible.
    logic [53:0] mem [0:511];
    logic [31:0] cyc = 32'd0;
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = {22'h2A_AAAA, 32'(i)};
    end
    always @(posedge clk) begin
        cyc <= cyc + 32'd1;
        if (!sram_cen && !sram_gwen) begin
            mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            sram_q      <= 54'h15_5A5A_0000_0000 ^ {22'd0, cyc};
        end else if (!sram_cen) begin
            sram_q <= mem[sram_a];
        end else begin
            sram_q <= 54'h2A_A5A5_0000_0000 ^ {22'd0, cyc};
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, settle, then let caller check.
    task automatic drive(input logic vld, input logic wr, input logic [8:0] addr,
                         input logic [53:0] wd, input logic [53:0] wm,
                         input logic rr, input logic ireq);
        @(negedge clk);
        cpurst_b  = rst_b_v;
        req_vld   = vld;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_wmask = wm;
        rsp_rdy   = rr;
        init_req  = ireq;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 9'd0, 54'd0, 54'd0, 1'b1, 1'b0);
    endtask

    // Sweep n cycles, expecting addresses 0..n-1 written with INIT_VAL.
    task automatic sweep(input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 9'd0, 54'd0, 54'd0, 1'b1, 1'b0);
            if (i == 0) begin
                chk("sweep_first_a", 64'(sram_a), 64'd0);
                chk("sweep_first_cen", 64'(sram_cen), 64'd0);
            end
            if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== 54'd0 ||
                sram_d !== 54'd0 || sram_a !== 9'(i) || req_rdy !== 1'b0 ||
                init_done !== 1'b0) bad++;
        end
        chk("sweep_cycles_bad", 64'(bad), 64'd0);
    endtask

    int xfers;
    int resp_cnt;

    initial begin
        // Reset
        rst_b_v = 1'b0;
        repeat (3) drive(1'b1, 1'b1, 9'd4, ONES, ONES, 1'b1, 1'b0);
        chk("rst_cen", 64'(sram_cen), 64'd1);
        chk("rst_gwen", 64'(sram_gwen), 64'd1);
        chk("rst_wen", 64'(sram_wen), 64'(ONES));
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);

        // Full init sweep
        rst_b_v = 1'b1;
        sweep(512);
        idle();
        chk("init_done_513", 64'(init_done), 64'd1);
        chk("idle_cen", 64'(sram_cen), 64'd1);

        // Write then read-after-write on addr 5
        drive(1'b1, 1'b1, 9'd5, VAL5, ONES, 1'b1, 1'b0);
        chk("wr5_rdy", 64'(req_rdy), 64'd1);
        chk("wr5_cen", 64'(sram_cen), 64'd0);
        chk("wr5_gwen", 64'(sram_gwen), 64'd0);
        chk("wr5_a", 64'(sram_a), 64'd5);
        chk("wr5_d", 64'(sram_d), 64'(VAL5));
        chk("wr5_wen", 64'(sram_wen), 64'd0);
        drive(1'b1, 1'b0, 9'd5, 54'd0, 54'd0, 1'b1, 1'b0);
        chk("rd5_cen", 64'(sram_cen), 64'd0);
        chk("rd5_gwen", 64'(sram_gwen), 64'd1);
        chk("rd5_wen", 64'(sram_wen), 64'(ONES));
        chk("rd5_no_rsp_yet", 64'(rsp_vld), 64'd0);
        idle();
        chk("rd5_rsp_vld", 64'(rsp_vld), 64'd1);
        chk("rd5_rsp_data", 64'(rsp_rdata), 64'(VAL5));

        // Masked write on addr 7, then zero-mask write on addr 9
        drive(1'b1, 1'b1, 9'd7, {27'h7FF_FFFF, 27'h001_5555}, {27'd0, {27{1'b1}}}, 1'b1, 1'b0);
        chk("wr7_wen", 64'(sram_wen), 64'({{27{1'b1}}, 27'd0}));
        drive(1'b1, 1'b1, 9'd9, ONES, 54'd0, 1'b1, 1'b0);
        chk("wr9_cen", 64'(sram_cen), 64'd0);
        chk("wr9_wen", 64'(sram_wen), 64'(ONES));
        drive(1'b1, 1'b0, 9'd7, 54'd0, 54'd0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 9'd9, 54'd0, 54'd0, 1'b1, 1'b0);
        chk("rd7_data", 64'(rsp_rdata), 64'h15555);
        chk("rd7_vld", 64'(rsp_vld), 64'd1);
        idle();
        chk("rd9_data", 64'(rsp_rdata), 64'd0);
        idle();

        // Backpressure: read 5 held for 4 cycles
        xfers = 0;
        drive(1'b1, 1'b0, 9'd5, 54'd0, 54'd0, 1'b0, 1'b0);
        chk("bp_accept", 64'(req_rdy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 9'd6, 54'd0, 54'd0, 1'b0, 1'b0);
            chk("bp_vld", 64'(rsp_vld), 64'd1);
            chk("bp_data", 64'(rsp_rdata), 64'(VAL5));
            chk("bp_req_rdy", 64'(req_rdy), 64'd0);
            chk("bp_cen", 64'(sram_cen), 64'd1);
        end
        drive(1'b1, 1'b0, 9'd6, 54'd0, 54'd0, 1'b1, 1'b0);
        chk("bp_release_vld", 64'(rsp_vld), 64'd1);
        chk("bp_release_data", 64'(rsp_rdata), 64'(VAL5));
        chk("bp_release_rdy", 64'(req_rdy), 64'd0);
        if (rsp_vld && rsp_rdy) xfers++;
        drive(1'b1, 1'b0, 9'd6, 54'd0, 54'd0, 1'b1, 1'b0);
        if (rsp_vld && rsp_rdy) xfers++;
        chk("bp_one_xfer", 64'(xfers), 64'd1);
        chk("bp_next_accept", 64'(req_rdy), 64'd1);
        idle();
        chk("rd6_data", 64'(rsp_rdata), 64'd0);
        chk("rd6_vld", 64'(rsp_vld), 64'd1);

        // Back-to-back writes then reads 0..15
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 9'(i), {22'(i + 1), 32'hCAFE_0000 + 32'(i)}, ONES, 1'b1, 1'b0);
            chk("b2b_wr_rdy", 64'(req_rdy), 64'd1);
        end
        resp_cnt = 0;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) drive(1'b1, 1'b0, 9'(i), 54'd0, 54'd0, 1'b1, 1'b0);
            else        idle();
            if (i < 16) chk("b2b_rd_rdy", 64'(req_rdy), 64'd1);
            if (i > 0) begin
                chk("b2b_rsp_vld", 64'(rsp_vld), 64'd1);
                chk("b2b_rsp_data", 64'(rsp_rdata), 64'({22'(i), 32'hCAFE_0000 + 32'(i - 1)}));
            end
            if (rsp_vld) resp_cnt++;
        end
        chk("b2b_resp_cnt", 64'(resp_cnt), 64'd16);
        idle();
        chk("b2b_drained", 64'(rsp_vld), 64'd0);

        // Reset in the middle of a sweep
        rst_b_v = 1'b0;
        idle();
        rst_b_v = 1'b1;
        sweep(200);
        rst_b_v = 1'b0;
        idle();
        chk("midrst_cen", 64'(sram_cen), 64'd1);
        chk("midrst_gwen", 64'(sram_gwen), 64'd1);
        rst_b_v = 1'b1;
        sweep(512);
        idle();
        chk("reinit_done", 64'(init_done), 64'd1);

        // init_req while a read is held: restart waits for the hold to clear
        drive(1'b1, 1'b1, 9'd3, V3, ONES, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 9'd3, 54'd0, 54'd0, 1'b0, 1'b0);
        chk("ireq_rd_accept", 64'(req_rdy), 64'd1);
        drive(1'b0, 1'b0, 9'd0, 54'd0, 54'd0, 1'b0, 1'b1);
        chk("ireq_pend_data", 64'(rsp_rdata), 64'(V3));
        chk("ireq_pend_done", 64'(init_done), 64'd1);
        chk("ireq_pend_rdy", 64'(req_rdy), 64'd0);
        drive(1'b0, 1'b0, 9'd0, 54'd0, 54'd0, 1'b0, 1'b0);
        chk("ireq_hold_vld", 64'(rsp_vld), 64'd1);
        chk("ireq_hold_data", 64'(rsp_rdata), 64'(V3));
        chk("ireq_hold_cen", 64'(sram_cen), 64'd1);
        chk("ireq_hold_done", 64'(init_done), 64'd1);
        drive(1'b1, 1'b0, 9'd0, 54'd0, 54'd0, 1'b1, 1'b0);
        chk("ireq_xfer_vld", 64'(rsp_vld), 64'd1);
        chk("ireq_xfer_data", 64'(rsp_rdata), 64'(V3));
        chk("ireq_xfer_rdy", 64'(req_rdy), 64'd0);
        drive(1'b1, 1'b0, 9'd0, 54'd0, 54'd0, 1'b1, 1'b0);
        chk("ireq_switch_rdy", 64'(req_rdy), 64'd0);
        chk("ireq_switch_vld", 64'(rsp_vld), 64'd0);
        chk("ireq_switch_cen", 64'(sram_cen), 64'd1);
        sweep(512);
        idle();
        chk("ireq_done", 64'(init_done), 64'd1);
        drive(1'b1, 1'b0, 9'd3, 54'd0, 54'd0, 1'b1, 1'b0);
        idle();
        chk("ireq_cleared_vld", 64'(rsp_vld), 64'd1);
        chk("ireq_cleared_data", 64'(rsp_rdata), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
